// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: capture FSM states and default byte width.
package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_ACK  = 1'b1
    } cap_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DW register array with one write port and one registered read port.
module sync_fifo_mem import uart_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int DW    = UART_DW
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DW-1:0]            o_rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // NOTE: the storage array has no reset; count and pointers define validity.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures each receiver byte once, acknowledges it, and releases paced strobes.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int DEPTH   = 16,
    parameter int DW      = UART_DW,
    parameter int STB_GAP = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [DW-1:0]          i_rx_word,
    input  logic                   i_rx_rxne,
    input  logic                   i_rx_ore,
    output logic                   o_rxne_clear,
    output logic [DW-1:0]          o_data,
    output logic                   o_stb,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_overflow,
    input  logic                   i_overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(STB_GAP + 2);

    cap_state_e    state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          empty_q, full_q, stb_q, ovf_q, ovf_d;
    logic          wr_en, drop, pop;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            CAP_IDLE: begin
                if (i_rx_rxne) begin
                    state_d = CAP_ACK;
                    wr_en   = !full_q;
                    drop    = full_q;
                end
            end
            CAP_ACK: begin
                if (!i_rx_rxne) begin
                    state_d = CAP_IDLE;
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    // A full FIFO drops the incoming byte even if a pop frees a slot on the same edge.
    assign pop = !empty_q && i_ready && (gap_q == '0);

    always_comb begin
        wptr_d  = wptr_q + AW'(wr_en);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(wr_en) - CW'(pop);
        gap_d   = gap_q;
        if (pop) begin
            gap_d = GW'(STB_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
        ovf_d = ovf_q;
        if (drop || i_rx_ore) begin
            ovf_d = 1'b1;
        end else if (i_overflow_clr) begin
            ovf_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= CAP_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            gap_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            stb_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            gap_q   <= gap_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
            stb_q   <= pop;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_we      (wr_en),
        .i_waddr   (wptr_q),
        .i_wdata   (i_rx_word),
        .i_re      (pop),
        .i_raddr   (rptr_q),
        .o_rdata   (o_data)
    );

    assign o_rxne_clear = (state_q == CAP_ACK);
    assign o_stb        = stb_q;
    assign o_count      = count_q;
    assign o_empty      = empty_q;
    assign o_full       = full_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: per-cycle vector table plus hand-written corner sequences.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_word;
    logic       rx_rxne, rx_ore, ready, ovf_clr;
    logic       o_rxne_clear, o_stb, o_empty, o_full, o_overflow;
    logic [7:0] o_data;
    logic [4:0] o_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_rx_word      (rx_word),
        .i_rx_rxne      (rx_rxne),
        .i_rx_ore       (rx_ore),
        .o_rxne_clear   (o_rxne_clear),
        .o_data         (o_data),
        .o_stb          (o_stb),
        .i_ready        (ready),
        .o_count        (o_count),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_overflow     (o_overflow),
        .i_overflow_clr (ovf_clr)
    );

    typedef struct {
        logic       rxne;
        logic [7:0] word;
        logic       rdy;
        logic       ore;
        logic       clr;
        logic       e_clear;
        logic       e_stb;
        logic [7:0] e_data;
        int         e_count;
        logic       e_ovf;
    } vec_t;

    vec_t tv [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_rxne = 1'b1;
        rx_word = b;
        n = 0;
        do begin step(); n++; end while (!o_rxne_clear && n < 8);
        check("send_ack", o_rxne_clear, 1);
        rx_rxne = 1'b0;
        n = 0;
        do begin step(); n++; end while (o_rxne_clear && n < 8);
        check("send_release", o_rxne_clear, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clear"}, o_rxne_clear, 0);
        check({tag, "_stb"},   o_stb, 0);
        check({tag, "_data"},  o_data, 0);
        check({tag, "_count"}, o_count, 0);
        check({tag, "_empty"}, o_empty, 1);
        check({tag, "_full"},  o_full, 0);
        check({tag, "_ovf"},   o_overflow, 0);
    endtask

    initial begin
        logic [7:0] exp_q [$];
        int k, cyc, last;

        //        rxne  word   rdy ore clr | clear stb data  cnt ovf
        tv[0]  = '{1'b1, 8'h3A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0};
        tv[1]  = '{1'b0, 8'h3A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3A, 0, 1'b0};
        tv[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3A, 0, 1'b0};
        tv[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3A, 0, 1'b0};
        tv[4]  = '{1'b1, 8'hC4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3A, 1, 1'b0};
        tv[5]  = '{1'b1, 8'hC4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC4, 0, 1'b0};
        tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC4, 0, 1'b0};
        tv[7]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC4, 1, 1'b0};
        tv[8]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC4, 1, 1'b0};
        tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 0, 1'b0};
        tv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 0, 1'b1};
        tv[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 0, 1'b0};

        rst_n = 1'b0; rx_word = '0; rx_rxne = 1'b0; rx_ore = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single-byte handshakes, pacing and flag set/clear, one row per clock.
        for (int i = 0; i < 12; i++) begin
            rx_rxne = tv[i].rxne; rx_word = tv[i].word; ready = tv[i].rdy;
            rx_ore  = tv[i].ore;  ovf_clr = tv[i].clr;
            step();
            check($sformatf("vec%0d_clear", i), o_rxne_clear, tv[i].e_clear);
            check($sformatf("vec%0d_stb", i),   o_stb, tv[i].e_stb);
            check($sformatf("vec%0d_data", i),  o_data, tv[i].e_data);
            check($sformatf("vec%0d_count", i), o_count, tv[i].e_count);
            check($sformatf("vec%0d_empty", i), o_empty, tv[i].e_count == 0);
            check($sformatf("vec%0d_full", i),  o_full, tv[i].e_count == 16);
            check($sformatf("vec%0d_ovf", i),   o_overflow, tv[i].e_ovf);
        end
        rx_rxne = 1'b0; rx_ore = 1'b0; ovf_clr = 1'b0; ready = 1'b0;

        // Stuck RXNE: one write only, acknowledge held throughout.
        rx_rxne = 1'b1; rx_word = 8'h55;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stuck_clear_high", o_rxne_clear, 1);
        end
        check("stuck_count", o_count, 1);
        rx_rxne = 1'b0;
        step();
        check("stuck_idle", o_rxne_clear, 0);
        ready = 1'b1;
        step();
        check("stuck_stb", o_stb, 1);
        check("stuck_data", o_data, 8'h55);
        ready = 1'b0;

        // Fill to full, drop the 17th byte, then drain with minimum spacing.
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check("fill_full", o_full, 1);
        check("fill_count", o_count, 16);
        check("fill_ovf_clean", o_overflow, 0);
        send_byte(8'h10);
        check("drop_ovf", o_overflow, 1);
        check("drop_count", o_count, 16);
        ready = 1'b1;
        k = 0; cyc = 0; last = 0;
        while (k < 16 && cyc < 80) begin
            step(); cyc++;
            if (o_stb) begin
                check($sformatf("drain_data%0d", k), o_data, 8'(k));
                if (k > 0) check($sformatf("drain_gap%0d", k), cyc - last, 3);
                last = cyc; k++;
            end
        end
        check("drain_all", k, 16);
        ready = 1'b0;
        step();
        check("drain_empty", o_empty, 1);
        check("drain_ovf_sticky", o_overflow, 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("ovf_cleared", o_overflow, 0);

        // Streaming through pointer wrap with writes landing on pop cycles.
        ready = 1'b1;
        for (int i = 0; i < 40; i++) exp_q.push_back(8'(i * 7 + 3));
        fork
            begin
                for (int i = 0; i < 40; i++) send_byte(8'(i * 7 + 3));
            end
            begin
                int got = 0, sim = 0, mcyc = 0;
                logic [4:0] prev_cnt;
                logic prev_clr;
                prev_cnt = o_count; prev_clr = o_rxne_clear;
                while (got < 40 && mcyc < 400) begin
                    step(); mcyc++;
                    if (o_stb) begin
                        check($sformatf("wrap_data%0d", got), o_data, exp_q[got]);
                        got++;
                        if (o_rxne_clear && !prev_clr) begin
                            sim++;
                            check("simul_count", o_count, prev_cnt);
                        end
                    end
                    prev_cnt = o_count; prev_clr = o_rxne_clear;
                end
                check("wrap_all", got, 40);
                check("simul_seen", sim > 0, 1);
            end
        join
        ready = 1'b0;

        // Overrun pulse, then clear racing a full-drop.
        rx_ore = 1'b1; step(); rx_ore = 1'b0;
        check("ore_ovf", o_overflow, 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("ore_cleared", o_overflow, 0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
        check("race_full", o_full, 1);
        rx_rxne = 1'b1; rx_word = 8'hAA; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("race_set_wins", o_overflow, 1);
        check("race_ack", o_rxne_clear, 1);
        check("race_count", o_count, 16);
        rx_rxne = 1'b0; step();
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        ready = 1'b1; rx_rxne = 1'b1; rx_word = 8'hBB;
        step();
        ready = 1'b0;
        check("popdrop_stb", o_stb, 1);
        check("popdrop_data", o_data, 8'hA0);
        check("popdrop_count", o_count, 15);
        check("popdrop_ovf", o_overflow, 1);
        rx_rxne = 1'b0; step();

        // Asynchronous reset with 5 bytes stored and the FSM in ACK.
        rst_n = 1'b0; #3; rst_n = 1'b1;
        step();
        rx_ore = 1'b1; step(); rx_ore = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h60 + i));
        rx_rxne = 1'b1; rx_word = 8'h64;
        step();
        check("pre_rst_count", o_count, 5);
        check("pre_rst_ack", o_rxne_clear, 1);
        check("pre_rst_ovf", o_overflow, 1);
        rx_word = 8'h77;
        #2; rst_n = 1'b0; #1;
        check_reset_outputs("async_rst");
        #10; rst_n = 1'b1;
        step();
        check("post_rst_count", o_count, 1);
        check("post_rst_ack", o_rxne_clear, 1);
        rx_rxne = 1'b0; ready = 1'b1;
        step();
        check("post_rst_stb", o_stb, 1);
        check("post_rst_data", o_data, 8'h77);
        check("post_rst_empty", o_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
